// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Optional feature macro used by this slice: FETCH_MISALIGN_TRAP_EN.
package fetch_pkg;

    localparam int          INSTR_W    = 32;
    localparam logic [31:0] HALT_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP    = 32'd4;
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;

    typedef enum logic [1:0] {
        FS_IDLE,
        FS_RUN,
        FS_HALT
    } fetch_state_e;

    typedef enum logic [1:0] {
        PC_HOLD,
        PC_INC,
        PC_REDIR
    } pc_sel_e;

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC select (hold / +4 / redirect) with redirect alignment.
// With FETCH_MISALIGN_TRAP_EN the raw target is kept and flagged; otherwise it is word-aligned.
module fetch_next_pc
    import fetch_pkg::*;
(
    input  pc_sel_e     sel,
    input  logic [31:0] fetch_pc,
    input  logic [31:0] redirect_target,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic        misaligned,
`endif
    output logic [31:0] next_pc
);

    logic [31:0] redir_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign misaligned = |redirect_target[1:0];
    assign redir_pc   = redirect_target;
`else
    logic unused_low_bits;
    assign unused_low_bits = ^redirect_target[1:0];
    assign redir_pc        = {redirect_target[31:2], 2'b00};
`endif

    always_comb begin
        next_pc = fetch_pc;
        case (sel)
            PC_INC:   next_pc = fetch_pc + PC_STEP;
            PC_REDIR: next_pc = redir_pc;
            default:  next_pc = fetch_pc;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, captures imem data into a registered IF/ID slot.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_unit
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    output logic [31:0]        imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_target,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [31:0]        if_pc,
    output logic [31:0]        if_pc_plus4,
    output logic [INSTR_W-1:0] if_instr,
    output logic               halted
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic               misalign_trap
`endif
);

    fetch_state_e       state_q, state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic               if_valid_q, if_valid_d;
    logic [31:0]        if_pc_q, if_pc_d;
    logic [31:0]        if_pc_plus4_q, if_pc_plus4_d;
    logic [INSTR_W-1:0] if_instr_q, if_instr_d;
    logic               halted_q, halted_d;
    pc_sel_e            pc_sel;
    logic               adv;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic               trap_q, trap_d;
    logic               misaligned;
`endif

    fetch_next_pc u_next_pc (
        .sel             (pc_sel),
        .fetch_pc        (fetch_pc_q),
        .redirect_target (redirect_target),
`ifdef FETCH_MISALIGN_TRAP_EN
        .misaligned      (misaligned),
`endif
        .next_pc         (fetch_pc_d)
    );

    // The output slot can take a new word when empty or being drained this cycle.
    assign adv = !if_valid_q || if_ready;

    always_comb begin
        state_d       = state_q;
        pc_sel        = PC_HOLD;
        if_valid_d    = if_valid_q;
        if_pc_d       = if_pc_q;
        if_pc_plus4_d = if_pc_plus4_q;
        if_instr_d    = if_instr_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        trap_d        = trap_q;
`endif
        if (redirect_valid) begin
            pc_sel     = PC_REDIR;
            if_valid_d = 1'b0;
            state_d    = FS_RUN;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (misaligned) begin
                trap_d  = 1'b1;
                state_d = FS_HALT;
            end else begin
                trap_d  = 1'b0;
            end
`endif
        end else begin
            case (state_q)
                FS_IDLE: state_d = FS_RUN;
                FS_RUN: begin
                    if (adv) begin
                        if (imem_rdata == HALT_INSTR) begin
                            // End of program: drop the zero word and park the PC on it.
                            if_valid_d = 1'b0;
                            state_d    = FS_HALT;
                        end else begin
                            pc_sel        = PC_INC;
                            if_valid_d    = 1'b1;
                            if_pc_d       = fetch_pc_q;
                            if_pc_plus4_d = fetch_pc_q + PC_STEP;
                            if_instr_d    = imem_rdata;
                        end
                    end
                end
                FS_HALT: state_d = FS_HALT;
                default: state_d = FS_IDLE;
            endcase
        end
        halted_d = (state_d == FS_HALT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= FS_IDLE;
            fetch_pc_q    <= RESET_PC;
            if_valid_q    <= 1'b0;
            if_pc_q       <= 32'h0;
            if_pc_plus4_q <= PC_STEP;
            if_instr_q    <= '0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            if_valid_q    <= if_valid_d;
            if_pc_q       <= if_pc_d;
            if_pc_plus4_q <= if_pc_plus4_d;
            if_instr_q    <= if_instr_d;
            halted_q      <= halted_d;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) trap_q <= 1'b0;
        else     trap_q <= trap_d;
    end
    assign misalign_trap = trap_q;
`endif

    assign imem_addr   = fetch_pc_q;
    assign if_valid    = if_valid_q;
    assign if_pc       = if_pc_q;
    assign if_pc_plus4 = if_pc_plus4_q;
    assign if_instr    = if_instr_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed plan steps, then random traffic vs. a behavioural model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        if_valid;
    logic        if_ready = 1'b1;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic [31:0] if_instr;
    logic        halted;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign_trap;
`endif

    fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_pc           (if_pc),
        .if_pc_plus4     (if_pc_plus4),
        .if_instr        (if_instr),
        .halted          (halted)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .misalign_trap   (misalign_trap)
`endif
    );

    always #5 clk = ~clk;

    // 64-word memory, aliased over the whole address space by addr[7:2].
    logic [31:0] mem [64];
    assign imem_rdata = mem[imem_addr[7:2]];

    int total = 0;
    int bad   = 0;

    // Behavioural model: mode 0 = just out of reset, 1 = fetching, 2 = stopped.
    int          m_mode;
    logic [31:0] m_pc, m_opc, m_instr;
    bit          m_valid, m_trap;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_pc = 32'h0; m_opc = 32'h0; m_instr = 32'h0;
        m_valid = 0; m_trap = 0;
    endtask

    task automatic model_edge();
        logic [31:0] w;
        if (redirect_valid) begin
            m_valid = 0;
            m_mode  = 1;
`ifdef FETCH_MISALIGN_TRAP_EN
            m_pc = redirect_target;
            if (redirect_target % 4 != 0) begin
                m_trap = 1;
                m_mode = 2;
            end else begin
                m_trap = 0;
            end
`else
            m_pc = redirect_target - (redirect_target % 4);
`endif
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1 && (!m_valid || if_ready)) begin
            w = mem[(m_pc / 4) % 64];
            if (w == 0) begin
                m_valid = 0;
                m_mode  = 2;
            end else begin
                m_opc   = m_pc;
                m_instr = w;
                m_pc    = m_pc + 4;
                m_valid = 1;
            end
        end
    endtask

    task automatic check_all();
        chk("imem_addr", imem_addr, m_pc);
        chk("if_valid", {31'b0, if_valid}, {31'b0, m_valid});
        chk("if_pc", if_pc, m_opc);
        chk("if_pc_plus4", if_pc_plus4, m_opc + 32'd4);
        chk("if_instr", if_instr, m_instr);
        chk("halted", {31'b0, halted}, (m_mode == 2) ? 32'd1 : 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("misalign_trap", {31'b0, misalign_trap}, {31'b0, m_trap});
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic redirect(input logic [31:0] tgt);
        redirect_valid  = 1'b1;
        redirect_target = tgt;
        step();
        redirect_valid  = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom | 32'h1;
        mem[1]  = 32'h002081B3;
        mem[2]  = 32'h40308233;
        mem[10] = 32'h0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("rst_imem_addr", imem_addr, 32'h0);
        chk("rst_plus4", if_pc_plus4, 32'h4);
        rst = 1'b0;

        // First capture on the second edge after release
        step();
        chk("boot_no_valid", {31'b0, if_valid}, 32'd0);
        step();
        chk("boot_pc0", if_pc, 32'h0);
        chk("boot_valid", {31'b0, if_valid}, 32'd1);

        // Streaming
        step();
        chk("stream_pc4", if_pc, 32'h4);
        chk("stream_i1", if_instr, 32'h002081B3);
        step();
        chk("stream_pc8", if_pc, 32'h8);
        chk("stream_p4_8", if_pc_plus4, 32'hC);

        // Back-pressure
        if_ready = 1'b0;
        repeat (3) step();
        chk("bp_pc_held", if_pc, 32'h8);
        chk("bp_addr_held", imem_addr, 32'hC);
        if_ready = 1'b1;
        step();
        chk("bp_release", if_pc, 32'hC);

        // Redirect while stalled
        if_ready = 1'b0;
        redirect(32'h20);
        chk("redir_flush", {31'b0, if_valid}, 32'd0);
        chk("redir_addr", imem_addr, 32'h20);
        step();
        chk("redir_pc", if_pc, 32'h20);

        // Halt on zero word at 0x28
        if_ready = 1'b1;
        for (int i = 0; i < 20 && !halted; i++) step();
        chk("halt_reached", {31'b0, halted}, 32'd1);
        chk("halt_addr", imem_addr, 32'h28);
        chk("halt_last_pc", if_pc, 32'h24);
        repeat (2) step();
        redirect(32'h4);
        step();
        chk("unhalt_pc", if_pc, 32'h4);

        // Misaligned redirect
        redirect(32'h22);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("mis_trap", {31'b0, misalign_trap}, 32'd1);
        chk("mis_halt", {31'b0, halted}, 32'd1);
        step();
        redirect(32'h20);
        chk("mis_clear", {31'b0, misalign_trap}, 32'd0);
`else
        chk("mis_align", imem_addr, 32'h20);
`endif
        step();
        chk("mis_resume", if_pc, 32'h20);

        // PC wrap at top of address space
        redirect(32'hFFFF_FFFC);
        step();
        chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
        chk("wrap_p4", if_pc_plus4, 32'h0);
        chk("wrap_addr", imem_addr, 32'h0);

        // Random traffic, with occasional zero words and async resets
        for (int i = 0; i < 64; i++)
            mem[i] = ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom | 32'h1);
        for (int c = 0; c < 600; c++) begin
            if_ready = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 9))
                0:       redirect_target = 32'hFFFF_FFFC;
                1:       redirect_target = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
                default: redirect_target = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            endcase
            if ($urandom_range(0, 99) == 0) begin
                redirect_valid = 1'b0;
                #2;
                rst = 1'b1;
                #1;
                model_reset();
                check_all();
                @(posedge clk);
                #1;
                check_all();
                rst = 1'b0;
            end
            step();
        end
        redirect_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
